// File: rtl/game_pkg.sv
// Shared types and constants for the multi-player pool game controller:
// FSM states, difficulty level codes and the per-level strike budgets.
package game_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAim,
    StRoll,
    StEval,
    StEnd
  } state_e;

  localparam logic [3:0] LevelEasy   = 4'd1;
  localparam logic [3:0] LevelMedium = 4'd2;
  localparam logic [3:0] LevelHard   = 4'd3;

  localparam logic [6:0] EASY_MODE   = 7'd25;
  localparam logic [6:0] MEDIUM_MODE = 7'd20;
  localparam logic [6:0] HARD_MODE   = 7'd15;

  // Storage is always sized for the largest legal table.
  localparam int unsigned MaxPlayers = 4;

  function automatic logic level_legal(input logic [3:0] level);
    return (level == LevelEasy) || (level == LevelMedium) || (level == LevelHard);
  endfunction

  function automatic logic [6:0] level_budget(input logic [3:0] level);
    case (level)
      LevelEasy:   return EASY_MODE;
      LevelMedium: return MEDIUM_MODE;
      LevelHard:   return HARD_MODE;
      default:     return 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// 7-bit binary to two BCD digits; meaningful for inputs 0..99.
module bin2bcd (
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] units
);

  assign tens  = 4'(bin / 7'd10);
  assign units = 4'(bin % 7'd10);

endmodule

// File: rtl/multi_player_game_controller.sv
// Turn-based pool game controller: tracks per-player strike budgets and scores,
// hands the turn over after misses and fouls, and declares a winner at game end.
module multi_player_game_controller
  import game_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS  = 2,
  parameter int unsigned NUM_BALLS    = 8,
  parameter int unsigned FOUL_PENALTY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] level,
  input  logic       level_is_valid,
  input  logic       strike,
  input  logic       ballIn,
  input  logic       whiteballIn,
  input  logic       no_moving_flag,
  input  logic       win_cheatN,
  output logic       menu_state,
  output logic       game_state,
  output logic       end_state,
  output logic [1:0] current_player,
  output logic [1:0] winner,
  output logic       tie,
  output logic [3:0] strikes_units_digit,
  output logic [3:0] strikes_tens_digit,
  output logic [3:0] score_units_digit,
  output logic [3:0] score_tens_digit,
  output logic       lastThree
);

  state_e      state_q;
  logic [6:0]  strikes_q [MaxPlayers];
  logic [6:0]  scores_q  [MaxPlayers];
  logic [3:0]  balls_left_q;
  logic        pocketed_q;
  logic        foul_q;

  logic [6:0]  cur_strikes;
  logic [6:0]  cur_score;
  logic [6:0]  foul_strikes;
  logic [6:0]  strikes_after [MaxPlayers];
  logic        next_found;
  logic [1:0]  next_player;
  int unsigned cand;
  logic [1:0]  best_idx;
  logic [6:0]  best_score;
  logic        best_tie;

  always_comb begin
    cur_strikes  = strikes_q[current_player];
    cur_score    = scores_q[current_player];
    foul_strikes = (cur_strikes > 7'(FOUL_PENALTY)) ? cur_strikes - 7'(FOUL_PENALTY) : 7'd0;

    // Turn search sees the current player's post-foul budget so a fouled-out
    // player is skipped even when wrapping back to themselves.
    strikes_after = strikes_q;
    if (foul_q) strikes_after[current_player] = foul_strikes;

    next_found  = 1'b0;
    next_player = current_player;
    cand        = 0;
    for (int unsigned i = 1; i <= NUM_PLAYERS; i++) begin
      cand = (32'(current_player) + i) % NUM_PLAYERS;
      if (!next_found && strikes_after[2'(cand)] != 7'd0) begin
        next_found  = 1'b1;
        next_player = 2'(cand);
      end
    end

    best_idx   = 2'd0;
    best_score = scores_q[0];
    for (int unsigned i = 1; i < NUM_PLAYERS; i++) begin
      if (scores_q[i] > best_score) begin
        best_idx   = 2'(i);
        best_score = scores_q[i];
      end
    end
    best_tie = 1'b0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      if (2'(i) != best_idx && scores_q[i] == best_score) best_tie = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      balls_left_q   <= 4'(NUM_BALLS);
      pocketed_q     <= 1'b0;
      foul_q         <= 1'b0;
      current_player <= 2'd0;
      winner         <= 2'd0;
      tie            <= 1'b0;
      menu_state     <= 1'b1;
      game_state     <= 1'b0;
      end_state      <= 1'b0;
      for (int unsigned i = 0; i < MaxPlayers; i++) begin
        strikes_q[i] <= 7'd0;
        scores_q[i]  <= 7'd0;
      end
    end else if (!win_cheatN && state_q != StEnd) begin
      // Cheat beats everything else on this edge, including a strike.
      state_q    <= StEnd;
      winner     <= current_player;
      tie        <= 1'b0;
      menu_state <= 1'b0;
      game_state <= 1'b0;
      end_state  <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (level_is_valid && level_legal(level)) begin
            for (int unsigned i = 0; i < MaxPlayers; i++) begin
              strikes_q[i] <= (i < NUM_PLAYERS) ? level_budget(level) : 7'd0;
              scores_q[i]  <= 7'd0;
            end
            balls_left_q   <= 4'(NUM_BALLS);
            current_player <= 2'd0;
            state_q        <= StAim;
            menu_state     <= 1'b0;
            game_state     <= 1'b1;
          end
        end
        StAim: begin
          if (strike) begin
            strikes_q[current_player] <= (cur_strikes != 7'd0) ? cur_strikes - 7'd1 : 7'd0;
            pocketed_q <= 1'b0;
            foul_q     <= 1'b0;
            state_q    <= StRoll;
          end
        end
        StRoll: begin
          if (ballIn) begin
            scores_q[current_player] <= cur_score + 7'd1;
            if (balls_left_q != 4'd0) balls_left_q <= balls_left_q - 4'd1;
            pocketed_q <= 1'b1;
          end
          if (whiteballIn) foul_q <= 1'b1;
          if (no_moving_flag) state_q <= StEval;
        end
        StEval: begin
          if (foul_q && balls_left_q != 4'd0) strikes_q[current_player] <= foul_strikes;
          if (balls_left_q != 4'd0 && !foul_q && pocketed_q && cur_strikes != 7'd0) begin
            state_q <= StAim;
          end else if (balls_left_q != 4'd0 && next_found) begin
            current_player <= next_player;
            state_q        <= StAim;
          end else begin
            state_q    <= StEnd;
            winner     <= best_idx;
            tie        <= best_tie;
            game_state <= 1'b0;
            end_state  <= 1'b1;
          end
        end
        StEnd: ;
        default: state_q <= StIdle;
      endcase
    end
  end

  bin2bcd u_strikes_bcd (
    .bin   (cur_strikes),
    .tens  (strikes_tens_digit),
    .units (strikes_units_digit)
  );

  bin2bcd u_score_bcd (
    .bin   (cur_score),
    .tens  (score_tens_digit),
    .units (score_units_digit)
  );

  assign lastThree = (cur_strikes <= 7'd3);

endmodule

// File: tb/tb_multi_player_game_controller.sv
// Bench for the game controller: two instances (8 and 2 balls) share stimulus;
// a game-rules model predicts every cycle and a monitor compares from a queue.
module tb_multi_player_game_controller;

  localparam int NP = 2;
  localparam int FP = 1;
  localparam int PhIdle = 0, PhAim = 1, PhRoll = 2, PhEval = 3, PhEnd = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1, level_is_valid = 1'b0, strike = 1'b0, ballIn = 1'b0;
  logic       whiteballIn = 1'b0, no_moving_flag = 1'b0, win_cheatN = 1'b1;
  logic [3:0] level = 4'd0;

  logic       menu0, game0, end0, tie0, l30, menu1, game1, end1, tie1, l31;
  logic [1:0] cur0, win0, cur1, win1;
  logic [3:0] st_u0, st_t0, sc_u0, sc_t0, st_u1, st_t1, sc_u1, sc_t1;
  logic [24:0] act0, act1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multi_player_game_controller #(.NUM_PLAYERS(NP), .NUM_BALLS(8), .FOUL_PENALTY(FP)) dut0 (
    .clk(clk), .reset(reset), .level(level), .level_is_valid(level_is_valid),
    .strike(strike), .ballIn(ballIn), .whiteballIn(whiteballIn),
    .no_moving_flag(no_moving_flag), .win_cheatN(win_cheatN),
    .menu_state(menu0), .game_state(game0), .end_state(end0),
    .current_player(cur0), .winner(win0), .tie(tie0),
    .strikes_units_digit(st_u0), .strikes_tens_digit(st_t0),
    .score_units_digit(sc_u0), .score_tens_digit(sc_t0), .lastThree(l30)
  );

  multi_player_game_controller #(.NUM_PLAYERS(NP), .NUM_BALLS(2), .FOUL_PENALTY(FP)) dut1 (
    .clk(clk), .reset(reset), .level(level), .level_is_valid(level_is_valid),
    .strike(strike), .ballIn(ballIn), .whiteballIn(whiteballIn),
    .no_moving_flag(no_moving_flag), .win_cheatN(win_cheatN),
    .menu_state(menu1), .game_state(game1), .end_state(end1),
    .current_player(cur1), .winner(win1), .tie(tie1),
    .strikes_units_digit(st_u1), .strikes_tens_digit(st_t1),
    .score_units_digit(sc_u1), .score_tens_digit(sc_t1), .lastThree(l31)
  );

  assign act0 = {menu0, game0, end0, cur0, win0, tie0, st_t0, st_u0, sc_t0, sc_u0, l30};
  assign act1 = {menu1, game1, end1, cur1, win1, tie1, st_t1, st_u1, sc_t1, sc_u1, l31};

  // Game-rules model, one copy per instance (k=0: 8 balls, k=1: 2 balls).
  int m_ph[2], m_cur[2], m_balls[2], m_win[2];
  bit m_tie[2], m_poc[2], m_foul[2];
  int m_strk[2][4], m_score[2][4];

  function automatic int nballs(int k);
    return (k == 0) ? 8 : 2;
  endfunction

  function automatic void m_finish(int k);
    int best = 0;
    for (int p = 1; p < NP; p++) if (m_score[k][p] > m_score[k][best]) best = p;
    m_win[k] = best;
    m_tie[k] = 1'b0;
    for (int p = 0; p < NP; p++) if (p != best && m_score[k][p] == m_score[k][best]) m_tie[k] = 1'b1;
    m_ph[k] = PhEnd;
  endfunction

  function automatic void m_pass(int k);
    for (int d = 1; d <= NP; d++) begin
      int p = (m_cur[k] + d) % NP;
      if (m_strk[k][p] > 0) begin
        m_cur[k] = p;
        m_ph[k]  = PhAim;
        return;
      end
    end
    m_finish(k);
  endfunction

  function automatic void m_step(int k, bit rst, bit [3:0] lvl, bit lv, bit stk, bit bal,
                                 bit wht, bit stl, bit chn);
    if (rst) begin
      m_ph[k] = PhIdle; m_cur[k] = 0; m_win[k] = 0; m_tie[k] = 0;
      m_poc[k] = 0; m_foul[k] = 0; m_balls[k] = nballs(k);
      for (int p = 0; p < 4; p++) begin m_strk[k][p] = 0; m_score[k][p] = 0; end
      return;
    end
    if (!chn && m_ph[k] != PhEnd) begin
      m_ph[k] = PhEnd; m_win[k] = m_cur[k]; m_tie[k] = 0;
      return;
    end
    case (m_ph[k])
      PhIdle: if (lv && lvl >= 1 && lvl <= 3) begin
        for (int p = 0; p < 4; p++) begin
          m_strk[k][p]  = (p < NP) ? 30 - 5 * int'(lvl) : 0;
          m_score[k][p] = 0;
        end
        m_balls[k] = nballs(k); m_cur[k] = 0; m_ph[k] = PhAim;
      end
      PhAim: if (stk) begin
        if (m_strk[k][m_cur[k]] > 0) m_strk[k][m_cur[k]]--;
        m_poc[k] = 0; m_foul[k] = 0; m_ph[k] = PhRoll;
      end
      PhRoll: begin
        if (bal) begin
          m_score[k][m_cur[k]]++;
          if (m_balls[k] > 0) m_balls[k]--;
          m_poc[k] = 1;
        end
        if (wht) m_foul[k] = 1;
        if (stl) m_ph[k] = PhEval;
      end
      PhEval: begin
        if (m_balls[k] == 0) m_finish(k);
        else if (m_foul[k]) begin
          m_strk[k][m_cur[k]] = (m_strk[k][m_cur[k]] > FP) ? m_strk[k][m_cur[k]] - FP : 0;
          m_pass(k);
        end else if (m_poc[k] && m_strk[k][m_cur[k]] > 0) m_ph[k] = PhAim;
        else m_pass(k);
      end
      default: ;
    endcase
  endfunction

  function automatic logic [24:0] m_expect(int k);
    int s = m_strk[k][m_cur[k]];
    int c = m_score[k][m_cur[k]];
    return {(m_ph[k] == PhIdle), (m_ph[k] >= PhAim && m_ph[k] <= PhEval), (m_ph[k] == PhEnd),
            2'(m_cur[k]), 2'(m_win[k]), m_tie[k], 4'(s / 10), 4'(s % 10), 4'(c / 10),
            4'(c % 10), (s <= 3)};
  endfunction

  logic [24:0] q0[$], q1[$];
  string       qt[$];
  string       cur_tag = "reset";

  task automatic cycle(bit rst, bit [3:0] lvl, bit lv, bit stk, bit bal, bit wht, bit stl,
                       bit chn);
    @(negedge clk);
    reset = rst; level = lvl; level_is_valid = lv; strike = stk; ballIn = bal;
    whiteballIn = wht; no_moving_flag = stl; win_cheatN = chn;
    for (int k = 0; k < 2; k++) m_step(k, rst, lvl, lv, stk, bal, wht, stl, chn);
    q0.push_back(m_expect(0));
    q1.push_back(m_expect(1));
    qt.push_back(cur_tag);
  endtask

  task automatic idle();      cycle(0, 0, 0, 0, 0, 0, 0, 1); endtask
  task automatic do_reset();  cycle(1, 0, 0, 0, 0, 0, 0, 1); endtask
  task automatic start(bit [3:0] lvl); cycle(0, lvl, 1, 0, 0, 0, 0, 1); endtask

  task automatic shot(bit bal, bit wht);
    cycle(0, 0, 0, 1, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, bal, wht, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1, 1);
    idle();
  endtask

  // Waits for the edge that consumes the last applied cycle.
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [7:0] act, logic [7:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q0.size() != 0) begin
      logic [24:0] e0, e1;
      string t;
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      t  = qt.pop_front();
      tests += 2;
      if (act0 !== e0) begin
        fails++;
        $display("FAIL %s dut8 @%0t: got %h, required %h", t, $time, act0, e0);
      end
      if (act1 !== e1) begin
        fails++;
        $display("FAIL %s dut2 @%0t: got %h, required %h", t, $time, act1, e1);
      end
    end
  end

  initial begin
    do_reset(); do_reset(); settle();
    chk("reset_menu", 8'(menu0), 8'd1);
    chk("reset_end", 8'(end0), 8'd0);
    chk("reset_strikes_units", 8'(st_u0), 8'd0);

    cur_tag = "illegal_level";
    start(4'd0); start(4'd4); cycle(0, 0, 0, 1, 1, 0, 1, 1); settle();
    chk("illegal_level_menu", 8'(menu0), 8'd1);

    cur_tag = "pocket_keeps_turn";
    start(4'd1); shot(1, 0); settle();
    chk("pocket_cur", 8'(cur0), 8'd0);
    chk("pocket_strikes_tens", 8'(st_t0), 8'd2);
    chk("pocket_strikes_units", 8'(st_u0), 8'd4);
    chk("pocket_score_tens", 8'(sc_t0), 8'd0);
    chk("pocket_score_units", 8'(sc_u0), 8'd1);

    cur_tag = "miss_passes";
    do_reset(); start(4'd1); shot(0, 0); settle();
    chk("miss_cur", 8'(cur0), 8'd1);
    shot(0, 0); settle();
    chk("miss_back_cur", 8'(cur0), 8'd0);
    chk("miss_back_strikes", 8'({st_t0, st_u0}), 8'h24);

    cur_tag = "foul_hard";
    do_reset(); start(4'd3); shot(0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0, 1); settle();
    chk("foul_after_strike", 8'({st_t0, st_u0}), 8'h14);
    cycle(0, 0, 0, 0, 0, 1, 0, 1); cycle(0, 0, 0, 0, 0, 0, 1, 1); idle(); settle();
    chk("foul_turn_passes", 8'(cur0), 8'd0);
    shot(0, 0); settle();
    chk("foul_p1_strikes", 8'({st_t0, st_u0}), 8'h13);

    cur_tag = "last_ball_foul";
    do_reset(); start(4'd1);
    cycle(0, 0, 0, 1, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 1, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1, 1);
    idle(); settle();
    chk("two_ball_end", 8'(end1), 8'd1);
    chk("two_ball_winner", 8'(win1), 8'd0);
    chk("two_ball_tie", 8'(tie1), 8'd0);

    cur_tag = "exhaust_tie";
    do_reset(); start(4'd3);
    for (int n = 0; n < 60 && m_ph[0] != PhEnd; n++) shot(m_score[0][m_cur[0]] < 3, 0);
    settle();
    chk("exhaust_end", 8'(end0), 8'd1);
    chk("exhaust_winner", 8'(win0), 8'd0);
    chk("exhaust_tie", 8'(tie0), 8'd1);

    cur_tag = "cheat";
    do_reset(); start(4'd2); shot(0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0, 0); settle();
    chk("cheat_end", 8'(end0), 8'd1);
    chk("cheat_winner", 8'(win0), 8'd1);
    chk("cheat_game", 8'(game0), 8'd0);
    do_reset(); settle();
    chk("cheat_reset_menu", 8'(menu0), 8'd1);
    chk("cheat_reset_digits", 8'({st_t0, st_u0, sc_t0, sc_u0}), 8'h00);

    cur_tag = "random";
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 79) == 0, 4'($urandom_range(0, 4)), $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 199) != 0);
    end

    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (q0.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", q0.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_player_game_controller.md
MULTI_PLAYER_GAME_CONTROLLER -- requirements
Module: multi_player_game_controller

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, number of players taking turns; legal range 1..4.
REQ-002 Parameter NUM_BALLS, default 8, object balls on the table at game start; legal range 1..15.
REQ-003 Parameter FOUL_PENALTY, default 1, strikes removed from the fouling player on a white-ball pocket.
REQ-004 One clock `clk`; reset `reset` is synchronous and active-high.
REQ-005 Port list (name, direction, width, meaning):
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- level, in, 4, difficulty code: 1 easy, 2 medium, 3 hard.
- level_is_valid, in, 1, level qualifier.
- strike, in, 1, one-cycle cue strike pulse.
- ballIn, in, 1, one-cycle object-ball pocket pulse.
- whiteballIn, in, 1, one-cycle white-ball pocket pulse.
- no_moving_flag, in, 1, all balls at rest.
- win_cheatN, in, 1, active-low cheat that forces the end of the game.
- menu_state, out, 1, IDLE indicator.
- game_state, out, 1, AIM/ROLL/EVAL indicator.
- end_state, out, 1, END indicator.
- current_player, out, 2, index of the player whose turn it is.
- winner, out, 2, winning player index.
- tie, out, 1, top score shared by more than one player.
- strikes_units_digit / strikes_tens_digit, out, 4 each, current player's strikes as BCD.
- score_units_digit / score_tens_digit, out, 4 each, current player's pocketed count as BCD.
- lastThree, out, 1, current player's strikes <= 3.

Function
REQ-006 FSM states: IDLE, AIM, ROLL, EVAL, END. All transitions occur on the clk edge.
REQ-007 IDLE to AIM on level_is_valid with a legal level.
- On that edge, every player's strikes load the level budget: 25, 20 or 15.
- Scores clear to 0, balls_left loads NUM_BALLS, current_player loads 0.
- An illegal level is ignored and the FSM stays in IDLE.
REQ-008 AIM to ROLL on strike.
- The current player's strikes decrement by 1 on the same edge.
- Shot flags pocketed and foul clear on the same edge.
- strike is ignored in every state other than AIM.
REQ-009 ballIn effect:
- In ROLL, ballIn increments the current player's score, decrements balls_left and sets pocketed.
- In all other states, ballIn is ignored.
- balls_left saturates at 0.
REQ-010 In ROLL, whiteballIn sets foul; it is ignored in all other states.
REQ-011 ROLL to EVAL on the first cycle no_moving_flag=1, provided the cycle is at least one cycle after entering ROLL.
REQ-012 EVAL lasts exactly one cycle. Priority order:
- (a) balls_left==0 goes to END.
- (b) foul: the current player's strikes decrease by FOUL_PENALTY, saturating at 0, and the turn passes.
- (c) pocketed and strikes>0: same player, go to AIM.
- (d) otherwise the turn passes.
REQ-013 Turn pass selects the next index (mod NUM_PLAYERS) with strikes>0, searching from current+1 and wrapping to the current player last. If no player has strikes>0, go to END; otherwise go to AIM.
REQ-014 win_cheatN=0 in any state except END forces END on the next edge. The winner is current_player, and this overrides the score comparison.
REQ-015 In END, winner is the highest score, with ties resolved to the lowest index. tie=1 if another player has an equal score. END is left only by reset.
REQ-016 A ballIn and a whiteballIn in the same ROLL cycle are both applied.
REQ-017 A strike coincident with win_cheatN=0 is discarded; the cheat wins.
REQ-018 State outputs:
- menu_state, game_state and end_state are one-hot and registered.
- The BCD digits and lastThree are combinational from the current player's registers.
- The BCD digits are valid for values 0..99.

Reset
REQ-019 On reset=1 at a clk edge, the block returns to IDLE and clears every output and register:
- current_player=0, winner=0, tie=0.
- All strikes=0, all scores=0, balls_left=NUM_BALLS.
- menu_state=1, game_state=0, end_state=0.
REQ-020 Reset during ROLL or EVAL discards the shot in progress; no partial score or strike update survives.

Structure
REQ-021 Package game_pkg holds:
- the FSM state enum;
- level codes;
- constants EASY_MODE=25, MEDIUM_MODE=20, HARD_MODE=15;
- a function mapping level to budget.
REQ-022 Per-player strikes and scores are arrays indexed by player, each 7 bits wide.
REQ-023 A single sub-module bin2bcd (7-bit binary to tens/units) is instantiated twice, once for strikes and once for score.

Verification
REQ-024 NUM_PLAYERS=2, level=1:
- Player 0 strikes, pockets 1 ball, balls settle.
- Required: current_player stays 0; strikes digits read 2/4; score reads 0/1.
REQ-025 Player 0 strikes with no pocket, then balls settle.
- Required: current_player goes to 1 one cycle after EVAL; player 0 still shows 24 strikes when selected again.
REQ-026 Player 1 shot with whiteballIn, level=3, FOUL_PENALTY=1.
- Required: player 1 strikes go 15 -> 14 on the strike, then 13 in EVAL; turn passes to player 0.
REQ-027 NUM_BALLS=2; two ballIn pulses in one ROLL, the second coincident with whiteballIn.
- Required: END after EVAL; winner = shooter; tie=0.
REQ-028 Both players are exhausted to 0 strikes with scores 3 and 3.
- Required: END; winner=0; tie=1.
REQ-029 Mid-game checks:
- win_cheatN=0 in AIM with current_player=1 gives END next cycle with winner=1.
- A later reset=1 gives IDLE with menu_state=1 and all digits 0.
